// File: rtl/t08_lcd_bus_rx.sv
// Panel-side receiver for an 8080-style 8-bit LCD write bus: decodes commands/parameters,
// tracks the CASET/PASET address window and assembles memory-write bytes into RGB565 pixels.
// Latency: every pulse output is registered, one cycle after the wrx rising-edge cycle.
// Backpressure: none; the bus has no ready, so every strobe with csx low is accepted.
// Ports: clk/nrst; bus_data, csx, dcx, wrx, rdx (rdx unused) in; cmd/param/pixel pulse+data,
// address window, display_on, sleeping, colmod, madctl out.
module t08_lcd_bus_rx #(
  parameter int unsigned X_MAX = 239,
  parameter int unsigned Y_MAX = 319
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  bus_data,
  input  logic        csx,
  input  logic        dcx,
  input  logic        wrx,
  input  logic        rdx,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic        param_valid,
  output logic [7:0]  param_byte,
  output logic [3:0]  param_idx,
  output logic        pixel_valid,
  output logic [15:0] pixel,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [8:0]  col_start,
  output logic [8:0]  col_end,
  output logic [8:0]  page_start,
  output logic [8:0]  page_end,
  output logic        display_on,
  output logic        sleeping,
  output logic [7:0]  colmod,
  output logic [7:0]  madctl
);

  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [8:0] Y_LIM = 9'(Y_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_MEMWR_HI,
    ST_MEMWR_LO
  } state_e;

  // Read strobe is part of the bus but has no function on the write path.
  logic unused_rdx;
  assign unused_rdx = rdx;

  state_e      state_q, state_d;
  logic        wrx_q, csx_q;
  logic [3:0]  cnt_q, cnt_d;          // index of the next parameter byte
  logic [23:0] shadow_q, shadow_d;    // SC hi, SC lo, EC hi of a pending window update
  logic [7:0]  held_q, held_d;        // high pixel byte waiting for its partner
  logic [8:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;

  logic        cmd_valid_q, cmd_valid_d, param_valid_q, param_valid_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [7:0]  cmd_q, cmd_d, param_byte_q, param_byte_d;
  logic [3:0]  param_idx_q, param_idx_d;
  logic [15:0] pixel_q, pixel_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [8:0]  col_start_q, col_start_d, col_end_q, col_end_d;
  logic [8:0]  page_start_q, page_start_d, page_end_q, page_end_d;
  logic        display_on_q, display_on_d, sleeping_q, sleeping_d;
  logic [7:0]  colmod_q, colmod_d, madctl_q, madctl_d;

  logic take, csx_rise;
  assign take     = wrx && !wrx_q && !csx;
  assign csx_rise = csx && !csx_q;

  // Window coordinates arrive as 16-bit values; keep the low 9 bits, then clamp to the panel.
  function automatic logic [8:0] clamp9(input logic [7:0] hi, input logic [7:0] lo,
                                        input logic [8:0] lim);
    logic [8:0] v;
    v = {hi[0], lo};
    return (v > lim) ? lim : v;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    held_d        = held_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    cmd_valid_d   = 1'b0;
    param_valid_d = 1'b0;
    pixel_valid_d = 1'b0;
    cmd_d         = cmd_q;
    param_byte_d  = param_byte_q;
    param_idx_d   = param_idx_q;
    pixel_d       = pixel_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    col_start_d   = col_start_q;
    col_end_d     = col_end_q;
    page_start_d  = page_start_q;
    page_end_d    = page_end_q;
    display_on_d  = display_on_q;
    sleeping_d    = sleeping_q;
    colmod_d      = colmod_q;
    madctl_d      = madctl_q;

    // Going to IDLE is enough to drop a held pixel byte: it is only used from MEMWR_LO.
    if (csx_rise) begin
      state_d = ST_IDLE;
    end else if (take) begin
      if (!dcx) begin
        cmd_valid_d = 1'b1;
        cmd_d       = bus_data;
        param_idx_d = 4'd0;
        cnt_d       = 4'd0;
        state_d     = ST_CMD;
        case (bus_data)
          8'h01: begin
            col_start_d  = 9'd0;
            col_end_d    = X_LIM;
            page_start_d = 9'd0;
            page_end_d   = Y_LIM;
            display_on_d = 1'b0;
            sleeping_d   = 1'b1;
            colmod_d     = 8'h66;
            madctl_d     = 8'h00;
          end
          8'h10: sleeping_d   = 1'b1;
          8'h11: sleeping_d   = 1'b0;
          8'h28: display_on_d = 1'b0;
          8'h29: display_on_d = 1'b1;
          8'h2C: begin
            state_d = ST_MEMWR_HI;
            cur_x_d = col_start_q;
            cur_y_d = page_start_q;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          ST_CMD: begin
            param_valid_d = 1'b1;
            param_byte_d  = bus_data;
            param_idx_d   = cnt_q;
            if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
            if (cmd_q == 8'h2A || cmd_q == 8'h2B) begin
              case (cnt_q)
                4'd0: shadow_d[23:16] = bus_data;
                4'd1: shadow_d[15:8]  = bus_data;
                4'd2: shadow_d[7:0]   = bus_data;
                4'd3: begin
                  if (cmd_q == 8'h2A) begin
                    col_start_d = clamp9(shadow_q[23:16], shadow_q[15:8], X_LIM);
                    col_end_d   = clamp9(shadow_q[7:0], bus_data, X_LIM);
                  end else begin
                    page_start_d = clamp9(shadow_q[23:16], shadow_q[15:8], Y_LIM);
                    page_end_d   = clamp9(shadow_q[7:0], bus_data, Y_LIM);
                  end
                end
                default: ;
              endcase
            end
            if (cnt_q == 4'd0 && cmd_q == 8'h3A) colmod_d = bus_data;
            if (cnt_q == 4'd0 && cmd_q == 8'h36) madctl_d = bus_data;
          end
          ST_MEMWR_HI: begin
            held_d  = bus_data;
            state_d = ST_MEMWR_LO;
          end
          ST_MEMWR_LO: begin
            pixel_valid_d = 1'b1;
            pixel_d       = {held_q, bus_data};
            pix_x_d       = cur_x_q;
            pix_y_d       = cur_y_q;
            state_d       = ST_MEMWR_HI;
            // X_MAX/Y_MAX also terminate a row/column so an inverted window still wraps.
            if (cur_x_q == col_end_q || cur_x_q == X_LIM) begin
              cur_x_d = col_start_q;
              if (cur_y_q == page_end_q || cur_y_q == Y_LIM) cur_y_d = page_start_q;
              else                                           cur_y_d = cur_y_q + 9'd1;
            end else begin
              cur_x_d = cur_x_q + 9'd1;
            end
          end
          default: ;  // parameter bytes in IDLE are dropped
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      wrx_q         <= 1'b1;
      csx_q         <= 1'b1;
      cnt_q         <= 4'd0;
      shadow_q      <= 24'd0;
      held_q        <= 8'd0;
      cur_x_q       <= 9'd0;
      cur_y_q       <= 9'd0;
      cmd_valid_q   <= 1'b0;
      param_valid_q <= 1'b0;
      pixel_valid_q <= 1'b0;
      cmd_q         <= 8'd0;
      param_byte_q  <= 8'd0;
      param_idx_q   <= 4'd0;
      pixel_q       <= 16'd0;
      pix_x_q       <= 9'd0;
      pix_y_q       <= 9'd0;
      col_start_q   <= 9'd0;
      col_end_q     <= X_LIM;
      page_start_q  <= 9'd0;
      page_end_q    <= Y_LIM;
      display_on_q  <= 1'b0;
      sleeping_q    <= 1'b1;
      colmod_q      <= 8'h66;
      madctl_q      <= 8'h00;
    end else begin
      state_q       <= state_d;
      wrx_q         <= wrx;
      csx_q         <= csx;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      held_q        <= held_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      cmd_valid_q   <= cmd_valid_d;
      param_valid_q <= param_valid_d;
      pixel_valid_q <= pixel_valid_d;
      cmd_q         <= cmd_d;
      param_byte_q  <= param_byte_d;
      param_idx_q   <= param_idx_d;
      pixel_q       <= pixel_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      col_start_q   <= col_start_d;
      col_end_q     <= col_end_d;
      page_start_q  <= page_start_d;
      page_end_q    <= page_end_d;
      display_on_q  <= display_on_d;
      sleeping_q    <= sleeping_d;
      colmod_q      <= colmod_d;
      madctl_q      <= madctl_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd         = cmd_q;
  assign param_valid = param_valid_q;
  assign param_byte  = param_byte_q;
  assign param_idx   = param_idx_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel       = pixel_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign col_start   = col_start_q;
  assign col_end     = col_end_q;
  assign page_start  = page_start_q;
  assign page_end    = page_end_q;
  assign display_on  = display_on_q;
  assign sleeping    = sleeping_q;
  assign colmod      = colmod_q;
  assign madctl      = madctl_q;

endmodule

// File: tb/tb_t08_lcd_bus_rx.sv
// Bench for t08_lcd_bus_rx: directed bus sequences then random traffic, every byte checked
// against a transaction-level display model; bytes are written at the fastest legal rate.
module tb_t08_lcd_bus_rx;

  localparam int X_MAX = 239;
  localparam int Y_MAX = 319;
  localparam int M_IDLE = 0, M_CMD = 1, M_HI = 2, M_LO = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  bus_data;
  logic        csx, dcx, wrx, rdx;
  logic        cmd_valid, param_valid, pixel_valid, display_on, sleeping;
  logic [7:0]  cmd, param_byte, colmod, madctl;
  logic [3:0]  param_idx;
  logic [15:0] pixel;
  logic [8:0]  pix_x, pix_y, col_start, col_end, page_start, page_end;

  always #5 clk = ~clk;

  t08_lcd_bus_rx #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clk(clk), .nrst(nrst), .bus_data(bus_data), .csx(csx), .dcx(dcx), .wrx(wrx), .rdx(rdx),
    .cmd_valid(cmd_valid), .cmd(cmd), .param_valid(param_valid), .param_byte(param_byte),
    .param_idx(param_idx), .pixel_valid(pixel_valid), .pixel(pixel), .pix_x(pix_x),
    .pix_y(pix_y), .col_start(col_start), .col_end(col_end), .page_start(page_start),
    .page_end(page_end), .display_on(display_on), .sleeping(sleeping), .colmod(colmod),
    .madctl(madctl)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int m_mode, m_idx, m_held, m_cx, m_cy, m_prev_cs;
  int m_sh[4];
  int m_cs, m_ce, m_ps, m_pe, m_disp, m_sleep, m_colmod, m_madctl;
  // Expected outputs
  int e_cv, e_pv, e_xv, e_cmd, e_pb, e_pi, e_pix, e_px, e_py;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string w);
    chk({w, ".cmd_valid"},   32'(cmd_valid),   e_cv);
    chk({w, ".cmd"},         32'(cmd),         e_cmd);
    chk({w, ".param_valid"}, 32'(param_valid), e_pv);
    chk({w, ".param_byte"},  32'(param_byte),  e_pb);
    chk({w, ".param_idx"},   32'(param_idx),   e_pi);
    chk({w, ".pixel_valid"}, 32'(pixel_valid), e_xv);
    chk({w, ".pixel"},       32'(pixel),       e_pix);
    chk({w, ".pix_x"},       32'(pix_x),       e_px);
    chk({w, ".pix_y"},       32'(pix_y),       e_py);
    chk({w, ".col_start"},   32'(col_start),   m_cs);
    chk({w, ".col_end"},     32'(col_end),     m_ce);
    chk({w, ".page_start"},  32'(page_start),  m_ps);
    chk({w, ".page_end"},    32'(page_end),    m_pe);
    chk({w, ".display_on"},  32'(display_on),  m_disp);
    chk({w, ".sleeping"},    32'(sleeping),    m_sleep);
    chk({w, ".colmod"},      32'(colmod),      m_colmod);
    chk({w, ".madctl"},      32'(madctl),      m_madctl);
  endtask

  task automatic check_quiet(input string w);
    chk({w, ".cmd_valid"},   32'(cmd_valid),   32'd0);
    chk({w, ".param_valid"}, 32'(param_valid), 32'd0);
    chk({w, ".pixel_valid"}, 32'(pixel_valid), 32'd0);
  endtask

  task automatic model_regs_reset();
    m_cs = 0; m_ce = X_MAX; m_ps = 0; m_pe = Y_MAX;
    m_disp = 0; m_sleep = 1; m_colmod = 'h66; m_madctl = 0;
  endtask

  task automatic model_reset();
    model_regs_reset();
    m_mode = M_IDLE; m_idx = 0; m_held = 0; m_cx = 0; m_cy = 0; m_prev_cs = 1;
    e_cv = 0; e_pv = 0; e_xv = 0; e_cmd = 0; e_pb = 0; e_pi = 0; e_pix = 0; e_px = 0; e_py = 0;
  endtask

  function automatic int clamp(input int hi, input int lo, input int lim);
    int v;
    v = (hi * 256 + lo) % 512;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_take(input int d, input int b);
    if (d == 0) begin
      e_cv = 1; e_cmd = b; e_pi = 0; m_idx = 0;
      m_mode = (b == 'h2C) ? M_HI : M_CMD;
      if (b == 'h2C) begin m_cx = m_cs; m_cy = m_ps; end
      if (b == 'h01) model_regs_reset();
      if (b == 'h10) m_sleep = 1;
      if (b == 'h11) m_sleep = 0;
      if (b == 'h28) m_disp = 0;
      if (b == 'h29) m_disp = 1;
    end else if (m_mode == M_CMD) begin
      e_pv = 1; e_pb = b; e_pi = m_idx;
      if ((e_cmd == 'h2A || e_cmd == 'h2B) && m_idx < 4) begin
        m_sh[m_idx] = b;
        if (m_idx == 3 && e_cmd == 'h2A) begin
          m_cs = clamp(m_sh[0], m_sh[1], X_MAX); m_ce = clamp(m_sh[2], m_sh[3], X_MAX);
        end
        if (m_idx == 3 && e_cmd == 'h2B) begin
          m_ps = clamp(m_sh[0], m_sh[1], Y_MAX); m_pe = clamp(m_sh[2], m_sh[3], Y_MAX);
        end
      end
      if (e_cmd == 'h3A && m_idx == 0) m_colmod = b;
      if (e_cmd == 'h36 && m_idx == 0) m_madctl = b;
      if (m_idx < 15) m_idx++;
    end else if (m_mode == M_HI) begin
      m_held = b; m_mode = M_LO;
    end else if (m_mode == M_LO) begin
      e_xv = 1; e_pix = m_held * 256 + b; e_px = m_cx; e_py = m_cy;
      if (m_cx == m_ce || m_cx == X_MAX) begin
        m_cx = m_cs;
        m_cy = (m_cy == m_pe || m_cy == Y_MAX) ? m_ps : m_cy + 1;
      end else begin
        m_cx++;
      end
      m_mode = M_HI;
    end
  endtask

  // Called at a negedge: one cycle with wrx low, one with wrx high, then check the result.
  task automatic bus_byte(input int d, input int b, input int cs);
    wrx = 1'b0; dcx = d[0]; bus_data = 8'(b); csx = cs[0]; rdx = 1'($urandom_range(0, 1));
    if (cs == 1 && m_prev_cs == 0) m_mode = M_IDLE;
    m_prev_cs = cs;
    @(negedge clk);
    wrx = 1'b1;
    check_quiet("gap");
    @(negedge clk);
    e_cv = 0; e_pv = 0; e_xv = 0;
    if (cs == 0) model_take(d, b);
    check_all(cs != 0 ? "cs_hi_byte" : (d != 0 ? "data" : "command"));
  endtask

  task automatic csx_raise();
    csx = 1'b1;
    if (m_prev_cs == 0) m_mode = M_IDLE;
    m_prev_cs = 1;
    @(negedge clk);
    @(negedge clk);
    e_cv = 0; e_pv = 0; e_xv = 0;
    check_all("csx_rise");
  endtask

  task automatic do_reset();
    nrst = 1'b0; csx = 1'b1; wrx = 1'b1; dcx = 1'b0; bus_data = 8'd0; rdx = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    nrst = 1'b1;
    @(negedge clk);
  endtask

  function automatic int pick_cmd();
    int tbl[12] = '{'h00, 'h01, 'h10, 'h11, 'h28, 'h29, 'h2A, 'h2B, 'h2C, 'h2C, 'h36, 'h3A};
    int k;
    k = $urandom_range(0, 12);
    return (k == 12) ? int'($urandom_range(0, 255)) : tbl[k];
  endfunction

  function automatic int pick_param();
    if (m_mode == M_CMD && (e_cmd == 'h2A || e_cmd == 'h2B) && m_idx < 4) begin
      if (m_idx % 2 == 0) return ($urandom_range(0, 7) == 0) ? 1 : 0;
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(228, 255))
                                         : int'($urandom_range(0, 12));
    end
    return int'($urandom_range(0, 255));
  endfunction

  initial begin
    int r;
    do_reset();
    chk("rst.col_end",    32'(col_end),    32'd239);
    chk("rst.page_end",   32'(page_end),   32'd319);
    chk("rst.sleeping",   32'(sleeping),   32'd1);
    chk("rst.display_on", 32'(display_on), 32'd0);
    chk("rst.colmod",     32'(colmod),     32'h66);

    bus_byte(0, 'h29, 0);
    bus_byte(0, 'h11, 0);
    chk("on.display_on", 32'(display_on), 32'd1);
    chk("on.sleeping",   32'(sleeping),   32'd0);

    bus_byte(0, 'h2A, 0);
    bus_byte(1, 'h00, 0); bus_byte(1, 'h0A, 0); bus_byte(1, 'h00, 0); bus_byte(1, 'h0C, 0);
    chk("caset.param_idx", 32'(param_idx), 32'd3);
    bus_byte(0, 'h2B, 0);
    bus_byte(1, 'h00, 0); bus_byte(1, 'h14, 0); bus_byte(1, 'h00, 0); bus_byte(1, 'h15, 0);
    chk("win.col_start",  32'(col_start),  32'd10);
    chk("win.col_end",    32'(col_end),    32'd12);
    chk("win.page_start", 32'(page_start), 32'd20);
    chk("win.page_end",   32'(page_end),   32'd21);
    bus_byte(0, 'h2A, 0);
    bus_byte(1, 'h00, 0); bus_byte(1, 'h30, 0);
    csx_raise();
    bus_byte(1, 'h00, 0); bus_byte(1, 'h40, 0);
    chk("abort.col_start", 32'(col_start), 32'd10);
    chk("abort.col_end",   32'(col_end),   32'd12);

    bus_byte(0, 'h2C, 0);
    for (int p = 0; p < 7; p++) begin
      bus_byte(1, 'hF8, 0);
      bus_byte(1, 'h00, 0);
    end
    chk("wrap.pixel", 32'(pixel), 32'hF800);
    chk("wrap.pix_x", 32'(pix_x), 32'd10);
    chk("wrap.pix_y", 32'(pix_y), 32'd20);

    bus_byte(0, 'h2C, 0);
    bus_byte(1, 'hAB, 0); bus_byte(1, 'hCD, 0);
    chk("abcd.pixel", 32'(pixel), 32'hABCD);
    bus_byte(1, 'hEF, 0);
    csx_raise();
    bus_byte(0, 'h2C, 0);
    bus_byte(1, 'h12, 0);

    bus_byte(0, 'h2A, 0);
    bus_byte(1, 'h01, 0); bus_byte(1, 'hFF, 0); bus_byte(1, 'h01, 0); bus_byte(1, 'hFF, 0);
    chk("clamp.col_start", 32'(col_start), 32'd239);
    chk("clamp.col_end",   32'(col_end),   32'd239);
    bus_byte(0, 'h01, 0);
    chk("swrst.col_end",  32'(col_end),  32'd239);
    chk("swrst.col_start", 32'(col_start), 32'd0);
    chk("swrst.page_end", 32'(page_end), 32'd319);
    bus_byte(1, 'h55, 1); bus_byte(1, 'h66, 1);
    bus_byte(0, 'h3A, 0); bus_byte(1, 'h55, 0);
    bus_byte(0, 'h36, 0); bus_byte(1, 'hC8, 0);

    // Asynchronous reset between wrx fall and the taking edge of a low pixel byte.
    bus_byte(0, 'h2C, 0);
    bus_byte(1, 'h5A, 0);
    wrx = 1'b0; dcx = 1'b1; bus_data = 8'h3C;
    @(negedge clk);
    wrx = 1'b1;
    #2;
    nrst = 1'b0; csx = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    @(negedge clk);
    check_all("async_rst_hold");
    nrst = 1'b1;
    @(negedge clk);
    bus_byte(1, 'h77, 0);

    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       csx_raise();
      else if (r < 7)  bus_byte(1, $urandom_range(0, 255), 1);
      else if (r < 25) bus_byte(0, pick_cmd(), 0);
      else             bus_byte(1, pick_param(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
